// File: rtl/fft_frame_streamer.sv
// rtl/fft_frame_streamer.sv - replays overlapping frames from a loadable sample memory into an FFT input buffer
module fft_frame_streamer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_SIZE   = 400,
    parameter int NFFT         = 512,
    parameter int FRAME_HOP    = 160,
    parameter int NUM_FRAMES   = 4,
    parameter int MEM_DEPTH    = FRAME_HOP * (NUM_FRAMES - 1) + FRAME_SIZE,
    parameter int PTR_W        = $clog2(NFFT),
    parameter int ADDR_W       = $clog2(MEM_DEPTH),
    parameter int FIDX_W       = $clog2(NUM_FRAMES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_en_i,
    input  logic [ADDR_W-1:0]       load_addr_i,
    input  logic [SAMPLE_WIDTH-1:0] load_data_i,
    input  logic                    run_i,
    input  logic                    abort_i,
    input  logic                    stall_i,
    output logic                    sample_valid_o,
    output logic [PTR_W-1:0]        sample_ptr_o,
    output logic [SAMPLE_WIDTH-1:0] sample_o,
    output logic                    start_o,
    input  logic                    fft_done_i,
    output logic [FIDX_W-1:0]       frame_idx_o,
    output logic                    busy_o,
    output logic                    run_done_o
);

    typedef enum logic [1:0] {IDLE, STREAM, KICK, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [FIDX_W-1:0]       frame_idx_q, frame_idx_d;
    logic                    valid_q, valid_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [SAMPLE_WIDTH-1:0] data_q, data_d;
    logic                    start_q, start_d;
    logic                    run_done_q, run_done_d;

    logic [SAMPLE_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0]       rd_addr;
    logic [SAMPLE_WIDTH-1:0] rd_data;
    logic                    mem_we;

    // Sample memory is deliberately left out of reset so a reload is optional between runs.
    assign mem_we = load_en_i && (state_q == IDLE) && (32'(load_addr_i) < MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    assign rd_addr = base_q + ADDR_W'(cnt_q);
    assign rd_data = (32'(cnt_q) < FRAME_SIZE) ? mem[rd_addr] : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        frame_idx_d = frame_idx_q;
        valid_d     = 1'b0;
        ptr_d       = ptr_q;
        data_d      = data_q;
        start_d     = 1'b0;
        run_done_d  = 1'b0;
        if (abort_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            base_d      = '0;
            frame_idx_d = '0;
            ptr_d       = '0;
            data_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_i) begin
                        state_d     = STREAM;
                        cnt_d       = '0;
                        base_d      = '0;
                        frame_idx_d = '0;
                    end
                end
                STREAM: begin
                    if (!stall_i) begin
                        valid_d = 1'b1;
                        ptr_d   = cnt_q;
                        data_d  = rd_data;
                        if (cnt_q == PTR_W'(NFFT - 1)) begin
                            cnt_d   = '0;
                            state_d = KICK;
                        end else begin
                            cnt_d = cnt_q + PTR_W'(1);
                        end
                    end
                end
                KICK: begin
                    start_d = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (fft_done_i) begin
                        if (32'(frame_idx_q) < NUM_FRAMES - 1) begin
                            base_d      = base_q + ADDR_W'(FRAME_HOP);
                            frame_idx_d = frame_idx_q + FIDX_W'(1);
                            cnt_d       = '0;
                            state_d     = STREAM;
                        end else begin
                            run_done_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            frame_idx_q <= '0;
            valid_q     <= 1'b0;
            ptr_q       <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            frame_idx_q <= frame_idx_d;
            valid_q     <= valid_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            start_q     <= start_d;
            run_done_q  <= run_done_d;
        end
    end

    assign sample_valid_o = valid_q;
    assign sample_ptr_o   = ptr_q;
    assign sample_o       = data_q;
    assign start_o        = start_q;
    assign run_done_o     = run_done_q;
    assign frame_idx_o    = frame_idx_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb/tb_fft_frame_streamer.sv - scoreboard bench for fft_frame_streamer
module tb_fft_frame_streamer;

    localparam int SW   = 16;
    localparam int FS   = 400;
    localparam int NFFT = 512;
    localparam int HOP  = 160;
    localparam int NF   = 3;
    localparam int MD   = HOP * (NF - 1) + FS;
    localparam int AW   = $clog2(MD);
    localparam int PW   = $clog2(NFFT);
    localparam int FW   = $clog2(NF + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_en_i;
    logic [AW-1:0] load_addr_i;
    logic [SW-1:0] load_data_i;
    logic          run_i;
    logic          abort_i;
    logic          stall_i;
    logic          sample_valid_o;
    logic [PW-1:0] sample_ptr_o;
    logic [SW-1:0] sample_o;
    logic          start_o;
    logic          fft_done_i;
    logic [FW-1:0] frame_idx_o;
    logic          busy_o;
    logic          run_done_o;

    always #5 clk = ~clk;

    fft_frame_streamer #(
        .SAMPLE_WIDTH(SW), .FRAME_SIZE(FS), .NFFT(NFFT), .FRAME_HOP(HOP), .NUM_FRAMES(NF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
        .run_i(run_i), .abort_i(abort_i), .stall_i(stall_i),
        .sample_valid_o(sample_valid_o), .sample_ptr_o(sample_ptr_o), .sample_o(sample_o),
        .start_o(start_o), .fft_done_i(fft_done_i), .frame_idx_o(frame_idx_o),
        .busy_o(busy_o), .run_done_o(run_done_o)
    );

    typedef struct {
        logic [PW-1:0] ptr;
        logic [SW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [SW-1:0] model [MD];
    int            total = 0;
    int            bad = 0;
    int            starts = 0;
    int            dones = 0;
    logic          stall_en = 1'b0;
    logic          stall_seen = 1'b0;
    logic          prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int f);
        exp_t e;
        for (int k = 0; k < NFFT; k++) begin
            e.ptr  = PW'(k);
            e.data = (k < FS) ? model[HOP * f + k] : '0;
            q.push_back(e);
        end
    endtask

    always @(posedge clk) stall_seen <= stall_i;

    // Monitor: every presented sample is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid_o) begin
                if (stall_seen) chk("valid_while_stalled", 32'(sample_valid_o), 32'd0);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sample: got ptr %0d expected no sample", sample_ptr_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sample_ptr", 32'(sample_ptr_o), 32'(e.ptr));
                    chk("sample_data", 32'(sample_o), 32'(e.data));
                end
            end
            if (start_o) begin
                starts++;
                chk("start_after_last_valid", 32'(prev_valid), 32'd1);
                chk("start_valid_low", 32'(sample_valid_o), 32'd0);
                chk("start_frame_complete", 32'(q.size()), 32'd0);
            end
            if (run_done_o) dones++;
            prev_valid = sample_valid_o;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        int burst;
        int c;
        burst = 0;
        c = 0;
        stall_i = 1'b0;
        forever begin
            @(negedge clk);
            c++;
            if (!stall_en) begin
                stall_i = 1'b0;
                burst = 0;
            end else if (burst > 0) begin
                stall_i = 1'b1;
                burst--;
            end else if (sample_valid_o && sample_ptr_o == PW'(399)) begin
                stall_i = 1'b1;
                burst = 7;
            end else begin
                stall_i = (c % 3 == 0);
            end
        end
    end

    task automatic wait_start(input int target, input bit spurious, output bit got);
        got = 1'b0;
        for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
            @(negedge clk); #1;
            if (spurious && cyc == 40) begin
                fft_done_i  = 1'b1;
                run_i       = 1'b1;
                load_en_i   = 1'b1;
                load_addr_i = AW'(300);
                load_data_i = 16'h7777;
            end else begin
                fft_done_i = 1'b0;
                run_i      = 1'b0;
                load_en_i  = 1'b0;
            end
            if (starts >= target) got = 1'b1;
        end
        chk("start_seen", 32'(got), 32'd1);
    endtask

    task automatic do_run(input bit stalled, input bit spurious);
        int s0;
        int d0;
        bit got;
        s0 = starts;
        d0 = dones;
        push_frame(0);
        run_i = 1'b1;
        @(negedge clk); #1;
        run_i = 1'b0;
        chk("run_busy", 32'(busy_o), 32'd1);
        chk("run_no_early_valid", 32'(sample_valid_o), 32'd0);
        if (!stalled) begin
            @(negedge clk); #1;
            chk("first_valid_latency", 32'(sample_valid_o), 32'd1);
            chk("first_ptr", 32'(sample_ptr_o), 32'd0);
        end
        for (int f = 0; f < NF; f++) begin
            wait_start(s0 + f + 1, spurious && f == 0, got);
            if (!got) return;
            chk("frame_idx_at_start", 32'(frame_idx_o), 32'(f));
            repeat (10) @(negedge clk);
            #1;
            if (f < NF - 1) push_frame(f + 1);
            fft_done_i = 1'b1;
            @(negedge clk); #1;
            fft_done_i = 1'b0;
            if (f < NF - 1) begin
                chk("frame_advance", 32'(frame_idx_o), 32'(f + 1));
                chk("busy_between_frames", 32'(busy_o), 32'd1);
            end else begin
                chk("run_done_pulse", 32'(run_done_o), 32'd1);
                chk("idle_after_run", 32'(busy_o), 32'd0);
            end
        end
        @(negedge clk); #1;
        chk("run_done_one_cycle", 32'(run_done_o), 32'd0);
        chk("run_done_count", 32'(dones - d0), 32'd1);
        chk("start_count", 32'(starts - s0), 32'(NF));
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(sample_valid_o), 32'd0);
        chk({tag, "_ptr"}, 32'(sample_ptr_o), 32'd0);
        chk({tag, "_data"}, 32'(sample_o), 32'd0);
        chk({tag, "_start"}, 32'(start_o), 32'd0);
        chk({tag, "_run_done"}, 32'(run_done_o), 32'd0);
        chk({tag, "_frame_idx"}, 32'(frame_idx_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        bit got;
        int s0;
        int d0;
        int cyc;
        rst_n       = 1'b0;
        load_en_i   = 1'b0;
        load_addr_i = '0;
        load_data_i = '0;
        run_i       = 1'b0;
        abort_i     = 1'b0;
        fft_done_i  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Ramp load, with extreme values at the last real sample of frame 0 and the last memory word.
        for (int k = 0; k < MD; k++) begin
            load_en_i   = 1'b1;
            load_addr_i = AW'(k);
            load_data_i = (k == 399) ? 16'h8000 : (k == MD - 1) ? 16'hFFFF : SW'(k);
            model[k]    = load_data_i;
            @(negedge clk); #1;
        end
        load_en_i = 1'b0;

        do_run(1'b0, 1'b0);
        do_run(1'b0, 1'b1);
        stall_en = 1'b1;
        do_run(1'b1, 1'b0);
        stall_en = 1'b0;
        @(negedge clk); #1;

        // Abort at ptr 200 of frame 1.
        s0 = starts;
        d0 = dones;
        push_frame(0);
        run_i = 1'b1;
        @(negedge clk); #1;
        run_i = 1'b0;
        wait_start(s0 + 1, 1'b0, got);
        repeat (10) @(negedge clk);
        #1;
        push_frame(1);
        fft_done_i = 1'b1;
        @(negedge clk); #1;
        fft_done_i = 1'b0;
        got = 1'b0;
        for (cyc = 0; cyc < 2000 && !got; cyc++) begin
            @(negedge clk); #1;
            if (sample_valid_o && frame_idx_o == FW'(1) && sample_ptr_o == PW'(200)) got = 1'b1;
        end
        chk("abort_point_reached", 32'(got), 32'd1);
        abort_i = 1'b1;
        stall_i = 1'b0;
        q.delete();
        @(negedge clk); #1;
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_valid", 32'(sample_valid_o), 32'd0);
        chk("abort_frame_idx", 32'(frame_idx_o), 32'd0);
        repeat (20) @(negedge clk);
        #1;
        chk("abort_no_start", 32'(starts - s0), 32'd1);
        chk("abort_no_run_done", 32'(dones - d0), 32'd0);
        do_run(1'b0, 1'b0);

        // Asynchronous reset while waiting for fft_done_i.
        s0 = starts;
        push_frame(0);
        run_i = 1'b1;
        @(negedge clk); #1;
        run_i = 1'b0;
        wait_start(s0 + 1, 1'b0, got);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        do_run(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
